// File: rtl/lane_merger_if.sv
// lane_merger_if: four-lane input bus and merged output stream of lane_merger.
// lane_out exists only when LANE_MERGER_TAG_EN is defined.
interface lane_merger_if;
    logic [7:0] data_in0, data_in1, data_in2, data_in3;
    logic       valid_in0, valid_in1, valid_in2, valid_in3;
    logic       ready_in;
    logic [7:0] data_out;
    logic       valid_out;
`ifdef LANE_MERGER_TAG_EN
    logic [1:0] lane_out;
`endif
    logic       route_main;
    logic [3:0] fifo_full;
    logic       overflow;

    modport master(
`ifdef LANE_MERGER_TAG_EN
        input  lane_out,
`endif
        output data_in0, data_in1, data_in2, data_in3,
        output valid_in0, valid_in1, valid_in2, valid_in3, ready_in,
        input  data_out, valid_out, route_main, fifo_full, overflow
    );

    modport slave(
`ifdef LANE_MERGER_TAG_EN
        output lane_out,
`endif
        input  data_in0, data_in1, data_in2, data_in3,
        input  valid_in0, valid_in1, valid_in2, valid_in3, ready_in,
        output data_out, valid_out, route_main, fifo_full, overflow
    );
endinterface

// File: rtl/lane_merger.sv
// lane_merger: four per-lane FIFOs drained round-robin onto one registered valid/ready stream.
// Define LANE_MERGER_TAG_EN to store a source-lane tag per entry and drive lane_out.
module lane_merger #(
    parameter int FIFO_DEPTH  = 4,
    parameter int ALMOST_FULL = 2
) (
    input logic clk,
    input logic reset_L,
    lane_merger_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(ALMOST_FULL);

    typedef enum logic [1:0] {RESET, INIT, IDLE, ACTIVE} state_t;

    state_t        state;
    logic [7:0]    dataIn [4];
    logic [3:0]    validIn, full, nonEmpty, pop, push;
    logic [7:0]    mem [4][FIFO_DEPTH];
    logic [AW-1:0] rdPtr [4];
    logic [AW-1:0] wrPtr [4];
    logic [AW:0]   cnt [4];
    logic [1:0]    rrPtr, grant;
    logic          found, load, allLow;
    logic [7:0]    dataOut;
    logic          validOut, routeMain, overflowReg;
`ifdef LANE_MERGER_TAG_EN
    logic [1:0]    tagMem [4][FIFO_DEPTH];
    logic [1:0]    laneOut;
    assign bus.lane_out = laneOut;
`endif

    assign dataIn[0] = bus.data_in0;
    assign dataIn[1] = bus.data_in1;
    assign dataIn[2] = bus.data_in2;
    assign dataIn[3] = bus.data_in3;
    assign validIn   = {bus.valid_in3, bus.valid_in2, bus.valid_in1, bus.valid_in0};
    assign load      = !validOut || bus.ready_in;

    always_comb begin
        allLow = 1'b1;
        for (int k = 0; k < 4; k++) begin
            full[k]     = cnt[k] == FULL_CNT;
            nonEmpty[k] = cnt[k] != '0;
            if (cnt[k] >= AF_CNT) allLow = 1'b0;
        end
    end

    // Scan downward so the lane closest to rrPtr is the last, winning, assignment.
    always_comb begin
        grant = rrPtr;
        found = 1'b0;
        for (int k = 3; k >= 0; k--)
            if (nonEmpty[rrPtr + 2'(k)]) begin
                grant = rrPtr + 2'(k);
                found = 1'b1;
            end
    end

    // A full lane still accepts a push when it is being popped in the same cycle.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pop[k]  = load && found && grant == 2'(k);
            push[k] = validIn[k] && (!full[k] || pop[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            cnt   <= '{default: '0};
            rdPtr <= '{default: '0};
            wrPtr <= '{default: '0};
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (push[k]) begin
                    mem[k][wrPtr[k]] <= dataIn[k];
`ifdef LANE_MERGER_TAG_EN
                    tagMem[k][wrPtr[k]] <= 2'(k);
`endif
                    wrPtr[k] <= wrPtr[k] + 1'b1;
                end
                if (pop[k]) rdPtr[k] <= rdPtr[k] + 1'b1;
                cnt[k] <= cnt[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state       <= RESET;
            rrPtr       <= 2'd0;
            dataOut     <= 8'd0;
            validOut    <= 1'b0;
            routeMain   <= 1'b0;
            overflowReg <= 1'b0;
`ifdef LANE_MERGER_TAG_EN
            laneOut     <= 2'd0;
`endif
        end else begin
            if (|(validIn & full & ~pop)) overflowReg <= 1'b1;
            if (load) validOut <= found;
            if (load && found) begin
                dataOut <= mem[grant][rdPtr[grant]];
`ifdef LANE_MERGER_TAG_EN
                laneOut <= tagMem[grant][rdPtr[grant]];
`endif
                rrPtr   <= grant + 2'd1;
            end
            state <= state == RESET ? INIT :
                     state == INIT  ? IDLE :
                     state == IDLE  ? ((|validIn || |nonEmpty) ? ACTIVE : IDLE) :
                     ((!(|nonEmpty) && !validOut && !(|validIn)) ? IDLE : ACTIVE);
            routeMain <= state != RESET && allLow;
        end
    end

    assign bus.data_out   = dataOut;
    assign bus.valid_out  = validOut;
    assign bus.route_main = routeMain;
    assign bus.fifo_full  = full;
    assign bus.overflow   = overflowReg;
endmodule

// File: tb/tb_lane_merger.sv
// tb_lane_merger: table-driven vectors plus hand sequences for lane_merger, with an output scoreboard.
module tb_lane_merger;
    logic clk = 1'b0;
    logic reset_L = 1'b0;
    always #5 clk = ~clk;

    lane_merger_if bus();
    lane_merger #(.FIFO_DEPTH(4), .ALMOST_FULL(2)) dut (.clk(clk), .reset_L(reset_L), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic [1:0] lane;
    } exp_t;
    exp_t expQ[$];

    typedef struct {
        logic        rL;
        logic [3:0]  v;
        logic [31:0] d;
        logic        rdy;
        logic        eValid;
        logic [7:0]  eData;
        logic [1:0]  eLane;
        logic        eRoute;
    } vec_t;
    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic sb);
        bus.valid_in0 = v[0]; bus.valid_in1 = v[1]; bus.valid_in2 = v[2]; bus.valid_in3 = v[3];
        bus.data_in0 = d[7:0]; bus.data_in1 = d[15:8]; bus.data_in2 = d[23:16]; bus.data_in3 = d[31:24];
        if (sb)
            for (int i = 0; i < 4; i++)
                if (v[i]) expQ.push_back('{d: d[8*i +: 8], lane: 2'(i)});
    endtask

    task automatic cycle();
        logic       xfer;
        logic [7:0] d;
        logic [1:0] ln;
        exp_t       e;
        xfer = reset_L && bus.valid_out && bus.ready_in;
        d = bus.data_out;
`ifdef LANE_MERGER_TAG_EN
        ln = bus.lane_out;
`else
        ln = 2'd0;
`endif
        @(posedge clk);
        #1;
        if (!reset_L) expQ.delete();
        if (xfer) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL sb_extra got %0h want none", d);
            end else begin
                e = expQ.pop_front();
`ifdef LANE_MERGER_TAG_EN
                if (d !== e.d || ln !== e.lane) begin
`else
                if (d !== e.d) begin
`endif
                    errors++;
                    $display("FAIL sb_word got %0h/lane%0d want %0h/lane%0d", d, ln, e.d, e.lane);
                end
            end
        end
    endtask

    task automatic resetIdle();
        reset_L = 1'b0;
        bus.ready_in = 1'b1;
        drive(4'h0, 32'h0, 1'b0);
        cycle(); cycle();
        reset_L = 1'b1;
        cycle(); cycle();
    endtask

    initial begin
        int stale;
        vecs = '{
            '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0},
            '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b1},
            '{1'b1, 4'h4, 32'h00A50000, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 8'hA5, 2'd2, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b1},
            '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b0},
            '{1'b1, 4'hF, 32'h13121110, 1'b1, 1'b0, 8'h00, 2'd0, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 8'h10, 2'd0, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 8'h11, 2'd1, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 8'h12, 2'd2, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b1, 8'h13, 2'd3, 1'b1},
            '{1'b1, 4'h0, 32'h0,        1'b1, 1'b0, 8'h00, 2'd0, 1'b1}
        };
        bus.ready_in = 1'b1;
        drive(4'h0, 32'h0, 1'b0);

        foreach (vecs[i]) begin
            reset_L = vecs[i].rL;
            bus.ready_in = vecs[i].rdy;
            drive(vecs[i].v, vecs[i].d, 1'b1);
            cycle();
            chk($sformatf("vec%0d_valid", i), bus.valid_out, vecs[i].eValid);
            chk($sformatf("vec%0d_route", i), bus.route_main, vecs[i].eRoute);
            if (vecs[i].eValid) begin
                chk($sformatf("vec%0d_data", i), bus.data_out, vecs[i].eData);
`ifdef LANE_MERGER_TAG_EN
                chk($sformatf("vec%0d_lane", i), bus.lane_out, vecs[i].eLane);
`endif
            end
        end
        drive(4'h0, 32'h0, 1'b0);

        // backpressure hold on lane 1
        resetIdle();
        bus.ready_in = 1'b0;
        drive(4'h2, 32'h00000100, 1'b1); cycle();
        drive(4'h2, 32'h00000200, 1'b1); cycle();
        drive(4'h2, 32'h00000300, 1'b1); cycle();
        drive(4'h0, 32'h0, 1'b0);
        chk("bp_hold_valid", bus.valid_out, 1'b1);
        chk("bp_hold_data", bus.data_out, 8'h01);
        cycle();
        chk("bp_hold_data2", bus.data_out, 8'h01);
        chk("bp_route_drop", bus.route_main, 1'b0);
        bus.ready_in = 1'b1;
        cycle();
        chk("bp_rel_data", bus.data_out, 8'h02);
        cycle();
        chk("bp_rel_data2", bus.data_out, 8'h03);
        chk("bp_route_back", bus.route_main, 1'b1);
        cycle();
        chk("bp_drained", expQ.size(), 0);
        chk("bp_idle_valid", bus.valid_out, 1'b0);

        // overflow on lane 3
        resetIdle();
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'h8, {8'(8'h30 + i), 24'h0}, 1'b1);
            cycle();
        end
        chk("ov_full3", bus.fifo_full[3], 1'b1);
        chk("ov_not_yet", bus.overflow, 1'b0);
        drive(4'h8, 32'h35000000, 1'b0);
        cycle();
        drive(4'h0, 32'h0, 1'b0);
        chk("ov_set", bus.overflow, 1'b1);
        cycle();
        chk("ov_sticky", bus.overflow, 1'b1);
        bus.ready_in = 1'b1;
        for (int i = 0; i < 6; i++) cycle();
        chk("ov_drained", expQ.size(), 0);
        chk("ov_end_valid", bus.valid_out, 1'b0);
        chk("ov_sticky2", bus.overflow, 1'b1);

        // full lane 0 with a same-cycle pop
        resetIdle();
        bus.ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(4'h1, {24'h0, 8'(8'h40 + i)}, 1'b1);
            cycle();
        end
        chk("fp_full0", bus.fifo_full[0], 1'b1);
        bus.ready_in = 1'b1;
        drive(4'h1, 32'h00000045, 1'b1);
        cycle();
        drive(4'h0, 32'h0, 1'b0);
        chk("fp_no_overflow", bus.overflow, 1'b0);
        chk("fp_still_full", bus.fifo_full[0], 1'b1);
        for (int i = 0; i < 6; i++) cycle();
        chk("fp_drained", expQ.size(), 0);
        chk("fp_overflow_end", bus.overflow, 1'b0);

        // reset while three lanes hold data
        resetIdle();
        bus.ready_in = 1'b0;
        drive(4'h7, 32'h00525150, 1'b0); cycle();
        drive(4'h7, 32'h00626160, 1'b0); cycle();
        drive(4'h0, 32'h0, 1'b0);
        chk("rm_pre_valid", bus.valid_out, 1'b1);
        reset_L = 1'b0;
        cycle();
        chk("rm_valid", bus.valid_out, 1'b0);
        chk("rm_data", bus.data_out, 8'h00);
        chk("rm_route", bus.route_main, 1'b0);
        chk("rm_full", bus.fifo_full, 4'h0);
        chk("rm_overflow", bus.overflow, 1'b0);
`ifdef LANE_MERGER_TAG_EN
        chk("rm_lane", bus.lane_out, 2'd0);
`endif
        reset_L = 1'b1;
        bus.ready_in = 1'b1;
        stale = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (bus.valid_out) stale++;
        end
        chk("rm_no_stale", stale, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
